mmio_fabric: RTL and testbench
==============================

MMIO_FABRIC -- requirements
Module: mmio_fabric

Interface
REQ-001 The block SHALL use parameter N_SLV, default 4, for the number of slave regions (legal 1..8).
REQ-002 The block SHALL use parameter TIMEOUT, default 255, for the maximum WAIT cycles before abort (legal 1..65535).
REQ-003 The block SHALL have port clk, input, 1 bit: clock, all state on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have ports m_rd_en and m_wr_en, input, 1 bit each: master read and write requests, held until m_available.
REQ-006 The block SHALL have ports m_addr (32 bits), m_wr_data (32 bits) and m_ctrl (4 bits), input: master address, write data and byte control.
REQ-007 The block SHALL have ports m_rd_data (32 bits), m_available (1 bit) and m_err (1 bit), output: response data, response strobe and error flag.
REQ-008 The block SHALL have ports s_rd_en and s_wr_en, output, N_SLV bits each: per-slave one-hot strobes.
REQ-009 The block SHALL have ports s_addr (32 bits), s_wr_data (32 bits) and s_ctrl (4 bits), output: request fields shared by all slaves.
REQ-010 The block SHALL have port s_rd_data, input, N_SLV*32 bits: slave i read data in bits [32i+31:32i].
REQ-011 The block SHALL have port s_ready, input, N_SLV bits: slave i completion, one cycle, may coincide with the strobe.
REQ-012 The block SHALL have port err_count, output, 8 bits: saturating count of errored transactions.

Function
REQ-013 Region index SHALL be m_addr[31:28]; index < N_SLV maps to slave index; otherwise unmapped.
REQ-014 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP; requests SHALL be sampled only in IDLE and ignored elsewhere.
REQ-015 IDLE SHALL register addr, data, ctrl, region and direction on a request, then go to ISSUE; a mapped request SHALL NOT go straight to RESP.
REQ-016 If m_rd_en and m_wr_en are both high in IDLE, the request SHALL be taken as a write with error: no strobe issued, go to RESP with m_err=1.
REQ-017 An unmapped request SHALL issue no strobe and go IDLE->RESP with m_err=1 and m_rd_data=0.
REQ-018 ISSUE SHALL assert exactly one strobe bit (target, direction) for one cycle; s_addr, s_wr_data and s_ctrl SHALL hold the registered values from ISSUE through WAIT.
REQ-019 If s_ready[target] is high in ISSUE, the FSM SHALL go to RESP; otherwise it SHALL go to WAIT.
REQ-020 WAIT SHALL exit to RESP on s_ready[target]; s_ready from other slaves SHALL be ignored.
REQ-021 On a completing read, the target's s_rd_data SHALL be registered into m_rd_data; writes SHALL set m_rd_data=0.
REQ-022 RESP SHALL assert m_available for exactly one cycle with m_rd_data and m_err valid, then go to IDLE.
REQ-023 Minimum latency SHALL be 2 cycles from the sampling edge to m_available high (IDLE->ISSUE->RESP); back-to-back requests SHALL see one IDLE cycle between responses.
REQ-024 m_err SHALL be 0 outside RESP.
REQ-025 m_rd_data SHALL hold its value until the next response.
REQ-026 err_count SHALL increment on each RESP with m_err=1 and saturate at 255.

Reset
REQ-027 Asserting rst_n low SHALL force state to IDLE and all outputs to 0: m_available, m_err, m_rd_data, s_rd_en, s_wr_en, s_addr, s_wr_data, s_ctrl, err_count, and the timeout counter.
REQ-028 Reset mid-transaction SHALL abandon the transaction with no response, and no strobe SHALL appear in the cycle after release.
REQ-029 The first request SHALL be sampled on the first rising edge with rst_n high.

Configuration
REQ-030 The block SHALL use macro MMIO_FABRIC_TIMEOUT_EN to include or exclude the timeout logic.
REQ-031 With MMIO_FABRIC_TIMEOUT_EN defined, a 16-bit counter SHALL clear in ISSUE and increment each WAIT cycle; reaching TIMEOUT SHALL force RESP with m_err=1 and m_rd_data=0.
REQ-032 With MMIO_FABRIC_TIMEOUT_EN defined, s_ready arriving in the same cycle the counter reaches TIMEOUT SHALL win: normal completion, m_err=0.
REQ-033 Without MMIO_FABRIC_TIMEOUT_EN, the counter SHALL not exist and WAIT SHALL persist until s_ready; err_count SHALL count only unmapped and dual-request errors.

Verification
REQ-034 Read 0x1000_0004, with slave 1 s_ready in the ISSUE cycle and data 0xCAFE_0001 -> s_rd_en=4'b0010 for one cycle; m_available 2 cycles after sampling; m_rd_data=0xCAFE_0001; m_err=0.
REQ-035 Write 0x2000_0000 data 0x41, with slave 2 ready 3 cycles late -> s_wr_en=4'b0100 for one cycle; s_wr_data=0x41 held; m_available 5 cycles after sampling; m_rd_data=0.
REQ-036 Read 0x7000_0000 with N_SLV=4 -> no strobes; m_available next cycle; m_err=1; err_count 0->1.
REQ-037 With timeout enabled and TIMEOUT=8, slave 0 never ready -> m_err=1 after 8 WAIT cycles; with s_ready on cycle 8 instead -> m_err=0 with data.
REQ-038 rst_n low during WAIT -> outputs 0 immediately; no m_available; next read completes normally.
REQ-039 300 unmapped requests -> err_count saturates at 255.

Source files
------------

// File: rtl/mmio_fabric.sv
// mmio_fabric: single-master MMIO fabric that routes each request to one of
// N_SLV slave regions. The region is selected by m_addr[31:28].
// Each transaction runs IDLE -> ISSUE -> (WAIT) -> RESP and gives exactly one
// m_available pulse.
// Unmapped requests and simultaneous read+write requests get an immediate
// error response.
// Optional feature: define MMIO_FABRIC_TIMEOUT_EN to add a WAIT-state timeout
// that aborts a transaction after TIMEOUT cycles without s_ready.
module mmio_fabric #(
  parameter int N_SLV   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 m_rd_en,
  input  logic                 m_wr_en,
  input  logic [31:0]          m_addr,
  input  logic [31:0]          m_wr_data,
  input  logic [3:0]           m_ctrl,
  output logic [31:0]          m_rd_data,
  output logic                 m_available,
  output logic                 m_err,
  output logic [N_SLV-1:0]     s_rd_en,
  output logic [N_SLV-1:0]     s_wr_en,
  output logic [31:0]          s_addr,
  output logic [31:0]          s_wr_data,
  output logic [3:0]           s_ctrl,
  input  logic [N_SLV*32-1:0]  s_rd_data,
  input  logic [N_SLV-1:0]     s_ready,
  output logic [7:0]           err_count
);

  localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   tgt_q, tgt_d;
  logic               is_wr_q, is_wr_d;

  logic [31:0]        m_rd_data_d;
  logic               m_available_d;
  logic               m_err_d;
  logic [N_SLV-1:0]   s_rd_en_d;
  logic [N_SLV-1:0]   s_wr_en_d;
  logic [31:0]        s_addr_d;
  logic [31:0]        s_wr_data_d;
  logic [3:0]         s_ctrl_d;
  logic [7:0]         err_count_d;

  logic               req_any;
  logic               req_dual;
  logic               req_mapped;
  logic [IDX_W-1:0]   req_idx;
  logic               tgt_ready;
  logic [31:0]        tgt_data;
  logic               resp_go;
  logic               resp_err;
  logic [31:0]        resp_data;

`ifdef MMIO_FABRIC_TIMEOUT_EN
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT);
  logic [15:0]        tmo_q, tmo_d;
`endif

  // Error counter saturates instead of wrapping so a flood of errors stays visible.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign req_any    = m_rd_en | m_wr_en;
  assign req_dual   = m_rd_en & m_wr_en;
  assign req_mapped = (int'(m_addr[31:28]) < N_SLV);
  assign req_idx    = m_addr[28 +: IDX_W];
  assign tgt_ready  = s_ready[tgt_q];
  assign tgt_data   = s_rd_data[32*int'(tgt_q) +: 32];

  // Next-state and next-output logic. The outputs are registered, so every
  // strobe and response value is computed one state ahead.
  always_comb begin
    state_d       = state_q;
    tgt_d         = tgt_q;
    is_wr_d       = is_wr_q;
    m_rd_data_d   = m_rd_data;
    m_available_d = 1'b0;
    m_err_d       = 1'b0;
    s_rd_en_d     = '0;
    s_wr_en_d     = '0;
    s_addr_d      = s_addr;
    s_wr_data_d   = s_wr_data;
    s_ctrl_d      = s_ctrl;
    err_count_d   = err_count;
    resp_go       = 1'b0;
    resp_err      = 1'b0;
    resp_data     = '0;
`ifdef MMIO_FABRIC_TIMEOUT_EN
    tmo_d         = tmo_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_any) begin
          s_addr_d    = m_addr;
          s_wr_data_d = m_wr_data;
          s_ctrl_d    = m_ctrl;
          tgt_d       = req_idx;
          is_wr_d     = m_wr_en;
          if (req_dual || !req_mapped) begin
            // Ambiguous or unmapped requests never reach a slave.
            resp_go  = 1'b1;
            resp_err = 1'b1;
          end else begin
            state_d            = ISSUE;
            s_rd_en_d[req_idx] = m_rd_en;
            s_wr_en_d[req_idx] = m_wr_en;
          end
        end
      end

      ISSUE: begin
`ifdef MMIO_FABRIC_TIMEOUT_EN
        tmo_d = '0;
`endif
        if (tgt_ready) begin
          resp_go   = 1'b1;
          resp_data = is_wr_q ? 32'h0 : tgt_data;
        end else begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        // A ready arriving in the last allowed cycle takes priority over the timeout.
        if (tgt_ready) begin
          resp_go   = 1'b1;
          resp_data = is_wr_q ? 32'h0 : tgt_data;
        end
`ifdef MMIO_FABRIC_TIMEOUT_EN
        else begin
          tmo_d = tmo_q + 16'd1;
          if (tmo_d == TMO_LIMIT) begin
            resp_go  = 1'b1;
            resp_err = 1'b1;
          end
        end
`endif
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (resp_go) begin
      state_d       = RESP;
      m_available_d = 1'b1;
      m_err_d       = resp_err;
      m_rd_data_d   = resp_data;
      if (resp_err) begin
        err_count_d = sat_inc8(err_count);
      end
    end
  end

  // State register and registered outputs; the asynchronous reset abandons any
  // in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tgt_q       <= '0;
      is_wr_q     <= 1'b0;
      m_rd_data   <= '0;
      m_available <= 1'b0;
      m_err       <= 1'b0;
      s_rd_en     <= '0;
      s_wr_en     <= '0;
      s_addr      <= '0;
      s_wr_data   <= '0;
      s_ctrl      <= '0;
      err_count   <= '0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      is_wr_q     <= is_wr_d;
      m_rd_data   <= m_rd_data_d;
      m_available <= m_available_d;
      m_err       <= m_err_d;
      s_rd_en     <= s_rd_en_d;
      s_wr_en     <= s_wr_en_d;
      s_addr      <= s_addr_d;
      s_wr_data   <= s_wr_data_d;
      s_ctrl      <= s_ctrl_d;
      err_count   <= err_count_d;
    end
  end

`ifdef MMIO_FABRIC_TIMEOUT_EN
  // WAIT-cycle counter: cleared in ISSUE and advanced on each WAIT cycle without ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

endmodule

// File: tb/tb_mmio_fabric.sv
// tb_mmio_fabric: randomized self-checking bench for mmio_fabric.
// The bench models each transaction as its expected strobe, latency, error
// flag, data and error count. It plays the slaves, including ready noise on
// the slaves that are not targeted.
module tb_mmio_fabric;
  localparam int N_SLV = 4;
  localparam int TMO   = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 m_rd_en = 1'b0;
  logic                 m_wr_en = 1'b0;
  logic [31:0]          m_addr = '0;
  logic [31:0]          m_wr_data = '0;
  logic [3:0]           m_ctrl = '0;
  logic [31:0]          m_rd_data;
  logic                 m_available;
  logic                 m_err;
  logic [N_SLV-1:0]     s_rd_en;
  logic [N_SLV-1:0]     s_wr_en;
  logic [31:0]          s_addr;
  logic [31:0]          s_wr_data;
  logic [3:0]           s_ctrl;
  logic [N_SLV*32-1:0]  s_rd_data = '0;
  logic [N_SLV-1:0]     s_ready = '0;
  logic [7:0]           err_count;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_errcnt = 0;

  always #5 clk = ~clk;

  mmio_fabric #(.N_SLV(N_SLV), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m_rd_en    (m_rd_en),
    .m_wr_en    (m_wr_en),
    .m_addr     (m_addr),
    .m_wr_data  (m_wr_data),
    .m_ctrl     (m_ctrl),
    .m_rd_data  (m_rd_data),
    .m_available(m_available),
    .m_err      (m_err),
    .s_rd_en    (s_rd_en),
    .s_wr_en    (s_wr_en),
    .s_addr     (s_addr),
    .s_wr_data  (s_wr_data),
    .s_ctrl     (s_ctrl),
    .s_rd_data  (s_rd_data),
    .s_ready    (s_ready),
    .err_count  (err_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic check_zero(input string pfx);
    check_eq({pfx, "_m_available"}, 32'(m_available), 32'h0);
    check_eq({pfx, "_m_err"},       32'(m_err),       32'h0);
    check_eq({pfx, "_m_rd_data"},   m_rd_data,        32'h0);
    check_eq({pfx, "_s_rd_en"},     32'(s_rd_en),     32'h0);
    check_eq({pfx, "_s_wr_en"},     32'(s_wr_en),     32'h0);
    check_eq({pfx, "_s_addr"},      s_addr,           32'h0);
    check_eq({pfx, "_s_wr_data"},   s_wr_data,        32'h0);
    check_eq({pfx, "_s_ctrl"},      32'(s_ctrl),      32'h0);
    check_eq({pfx, "_err_count"},   32'(err_count),   32'h0);
  endtask

  // One master transaction. dly is the number of cycles after the ISSUE cycle
  // before the target slave raises s_ready (0 = same cycle as the strobe).
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] ctrl,
                         input logic [31:0] tdata, input int dly);
    int                  region;
    int                  exp_lat;
    bit                  mapped;
    bit                  live;
    bit                  done;
    logic                exp_err;
    logic [31:0]         exp_data;
    logic [N_SLV-1:0]    exp_rd;
    logic [N_SLV-1:0]    exp_wr;
    logic [N_SLV-1:0]    tmask;
    logic [N_SLV*32-1:0] rdv;

    region = int'(addr[31:28]);
    mapped = (region < N_SLV);
    live   = mapped && !(rd && wr);
    for (int i = 0; i < N_SLV; i++) rdv[i*32 +: 32] = $urandom;
    exp_rd = '0;
    exp_wr = '0;
    tmask  = '0;
    if (live) begin
      rdv[region*32 +: 32] = tdata;
      tmask[region] = 1'b1;
      if (rd) exp_rd[region] = 1'b1;
      else    exp_wr[region] = 1'b1;
      exp_lat  = 2 + dly;
      exp_err  = 1'b0;
      exp_data = rd ? tdata : 32'h0;
`ifdef MMIO_FABRIC_TIMEOUT_EN
      if (dly > TMO) begin
        exp_lat  = 2 + TMO;
        exp_err  = 1'b1;
        exp_data = 32'h0;
      end
`endif
    end else begin
      exp_lat  = 1;
      exp_err  = 1'b1;
      exp_data = 32'h0;
    end
    if (exp_err && exp_errcnt < 255) exp_errcnt++;

    @(negedge clk);
    s_rd_data = rdv;
    m_rd_en   = rd;
    m_wr_en   = wr;
    m_addr    = addr;
    m_wr_data = wdata;
    m_ctrl    = ctrl;
    s_ready   = N_SLV'($urandom) & ~tmask;
    @(posedge clk);
    done = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      check_eq("s_rd_en", 32'(s_rd_en), (c == 1) ? 32'(exp_rd) : 32'h0);
      check_eq("s_wr_en", 32'(s_wr_en), (c == 1) ? 32'(exp_wr) : 32'h0);
      if (live && c < exp_lat) begin
        check_eq("s_addr_hold",    s_addr,        addr);
        check_eq("s_wr_data_hold", s_wr_data,     wdata);
        check_eq("s_ctrl_hold",    32'(s_ctrl),   32'(ctrl));
      end
      if (m_available) begin
        check_eq("latency",   32'(c),         32'(exp_lat));
        check_eq("m_err",     32'(m_err),     32'(exp_err));
        check_eq("m_rd_data", m_rd_data,      exp_data);
        check_eq("err_count", 32'(err_count), 32'(exp_errcnt));
        done    = 1'b1;
        m_rd_en = 1'b0;
        m_wr_en = 1'b0;
        s_ready = '0;
      end else begin
        check_eq("m_err_outside_resp", 32'(m_err), 32'h0);
        s_ready = (N_SLV'($urandom) & ~tmask) | ((live && c == 1 + dly) ? tmask : '0);
      end
    end
    check_eq("resp_seen", 32'(done), 32'h1);
    m_rd_en = 1'b0;
    m_wr_en = 1'b0;
    s_ready = '0;
    @(negedge clk);
    check_eq("m_available_pulse", 32'(m_available), 32'h0);
    check_eq("m_err_after_resp",  32'(m_err),       32'h0);
    check_eq("m_rd_data_hold",    m_rd_data,        exp_data);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          r;
    int          sel;
    int          reg_i;
    logic [31:0] a;

    // Reset state
    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed: read with same-cycle ready, late write, unmapped read
    run_txn(1'b1, 1'b0, 32'h1000_0004, 32'h0, 4'hF, 32'hCAFE_0001, 0);
    run_txn(1'b0, 1'b1, 32'h2000_0000, 32'h41, 4'h1, 32'h0BAD_0BAD, 3);
    run_txn(1'b1, 1'b0, 32'h7000_0000, 32'h0, 4'hF, 32'h0, 0);
    check_eq("err_count_after_unmapped", 32'(err_count), 32'h1);
    run_txn(1'b1, 1'b1, 32'h0000_0010, 32'h55, 4'h3, 32'h1111_2222, 0);

`ifdef MMIO_FABRIC_TIMEOUT_EN
    run_txn(1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'h1, 32'hDEAD_BEEF, 100);
    run_txn(1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'h1, 32'h1357_9BDF, TMO);
`endif

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      reg_i = (r < 7) ? $urandom_range(0, N_SLV - 1) : $urandom_range(N_SLV, 15);
      a = {4'(reg_i), 28'($urandom)};
      sel = $urandom_range(0, 9);
      if (sel == 0)     run_txn(1'b1, 1'b1, a, $urandom, 4'($urandom), $urandom, $urandom_range(0, 6));
      else if (sel < 5) run_txn(1'b1, 1'b0, a, $urandom, 4'($urandom), $urandom, $urandom_range(0, 6));
      else              run_txn(1'b0, 1'b1, a, $urandom, 4'($urandom), $urandom, $urandom_range(0, 6));
    end

    // Error counter saturation
    for (int n = 0; n < 300; n++) begin
      run_txn(1'b1, 1'b0, {4'($urandom_range(N_SLV, 15)), 28'($urandom)}, 32'h0, 4'h0, 32'h0, 0);
    end
    check_eq("err_count_sat", 32'(err_count), 32'd255);

    // Reset while a read is stuck in WAIT
    @(negedge clk);
    m_rd_en   = 1'b1;
    m_addr    = 32'h1000_0010;
    m_wr_data = 32'h0000_1234;
    m_ctrl    = 4'hA;
    s_ready   = '0;
    @(posedge clk);
    repeat (3) @(negedge clk);
    check_eq("pre_rst_s_addr", s_addr, 32'h1000_0010);
    rst_n   = 1'b0;
    m_rd_en = 1'b0;
    #1;
    check_zero("rst_in_wait");
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_hold_m_available", 32'(m_available), 32'h0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("post_rst_m_available", 32'(m_available), 32'h0);
      check_eq("post_rst_s_rd_en",     32'(s_rd_en),     32'h0);
      check_eq("post_rst_s_wr_en",     32'(s_wr_en),     32'h0);
    end
    exp_errcnt = 0;
    run_txn(1'b1, 1'b0, 32'h3000_0008, 32'h0, 4'hF, 32'hA5A5_5A5A, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
